// File: rtl/mmult_opt_mdc_cfg_master.sv
// mmult_opt_mdc_cfg_master
// Launches one job on the mmult_opt_mdc HWPE through its peripheral
// configuration port. The sequence is: ACQUIRE a job slot (retrying with a
// back-off while the slot is busy), write the job parameters, write TRIGGER,
// then wait for the completion event. At most one transaction is in flight,
// and all request outputs are registered.
module mmult_opt_mdc_cfg_master #(
  parameter int          N_PARAMS  = 16,
  parameter int          ID        = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_RETRY = 255,
  parameter int          BACKOFF   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [N_PARAMS*32-1:0] params_i,
  input  logic                  evt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [7:0]            job_id_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic [31:0]           add_o,
  output logic                  wen_o,
  output logic [3:0]            be_o,
  output logic [31:0]           data_o,
  output logic [ID-1:0]         id_o,
  input  logic                  r_valid_i,
  input  logic [31:0]           r_data_i,
  input  logic [ID-1:0]         r_id_i
);

  localparam logic [31:0]   REG_TRIGGER = 32'h0000_0000;
  localparam logic [31:0]   REG_ACQUIRE = 32'h0000_0004;
  localparam logic [31:0]   REG_PARAM0  = 32'h0000_0040;
  localparam logic [5:0]    LAST_IDX    = 6'(N_PARAMS - 1);
  localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRY);
  localparam logic [15:0]   BO_LAST     = 16'(BACKOFF - 1);
  localparam logic [ID-1:0] TXN_ID      = '0;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ACQ_REQ  = 4'd1,
    S_ACQ_RSP  = 4'd2,
    S_BACKOFF  = 4'd3,
    S_WR_REQ   = 4'd4,
    S_WR_RSP   = 4'd5,
    S_TRIG_REQ = 4'd6,
    S_TRIG_RSP = 4'd7,
    S_WAIT_EVT = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  state_t                 r_state;
  logic [N_PARAMS*32-1:0] r_params;
  logic [5:0]             r_idx;
  logic [7:0]             r_retry;
  logic [15:0]            r_bo_cnt;
  logic                   r_evt;
  logic                   r_abort;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic [7:0]             r_job_id;
  logic                   r_req;
  logic [31:0]            r_add;
  logic                   r_wen;
  logic [31:0]            r_data;

  logic                   w_rsp_ok;
  logic [7:0]             w_retry_nxt;
  logic [N_PARAMS*32-1:0] w_param_vec;
  logic [31:0]            w_param;
  logic [31:0]            w_param_addr;
  logic                   w_unused;

  // A response counts only if it carries our (constant) transaction ID.
  assign w_rsp_ok     = r_valid_i && (r_id_i == TXN_ID);
  assign w_retry_nxt  = r_retry + 8'd1;
  assign w_param_vec  = r_params >> {r_idx, 5'd0};
  assign w_param      = w_param_vec[31:0];
  assign w_param_addr = BASE_ADDR + REG_PARAM0 + {24'd0, r_idx, 2'b00};
  // Only the busy flag and the job ID field of the ACQUIRE response matter.
  assign w_unused     = ^r_data_i[30:8];

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign error_o  = r_error;
  assign job_id_o = r_job_id;
  assign req_o    = r_req;
  assign add_o    = r_add;
  assign wen_o    = r_wen;
  assign data_o   = r_data;
  assign be_o     = 4'hF;
  assign id_o     = TXN_ID;

  // Job sequencer: state, request outputs and status outputs in one process.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_params <= '0;
      r_idx    <= 6'd0;
      r_retry  <= 8'd0;
      r_bo_cnt <= 16'd0;
      r_evt    <= 1'b0;
      r_abort  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_job_id <= 8'd0;
      r_req    <= 1'b0;
      r_add    <= 32'd0;
      r_wen    <= 1'b0;
      r_data   <= 32'd0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // busy_o still covers the done_o cycle, so a start there is ignored
          if (start_i && !r_busy) begin
            r_params <= params_i;
            r_retry  <= 8'd0;
            r_evt    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_ACQ_REQ;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_ACQ_REQ: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_add  <= BASE_ADDR + REG_ACQUIRE;
            r_wen  <= 1'b1;
            r_data <= 32'd0;
          end else if (gnt_i) begin
            r_req   <= 1'b0;
            r_state <= S_ACQ_RSP;
          end
        end
        S_ACQ_RSP: begin
          if (w_rsp_ok) begin
            if (!r_data_i[31]) begin
              r_job_id <= r_data_i[7:0];
              r_idx    <= 6'd0;
              r_state  <= S_WR_REQ;
            end else begin
              r_retry <= w_retry_nxt;
              if (w_retry_nxt == RETRY_LIMIT) begin
                r_abort <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_bo_cnt <= 16'd0;
                r_state  <= S_BACKOFF;
              end
            end
          end
        end
        S_BACKOFF: begin
          if (r_bo_cnt == BO_LAST) begin
            r_state <= S_ACQ_REQ;
          end else begin
            r_bo_cnt <= r_bo_cnt + 16'd1;
          end
        end
        S_WR_REQ: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_add  <= w_param_addr;
            r_wen  <= 1'b0;
            r_data <= w_param;
          end else if (gnt_i) begin
            r_req   <= 1'b0;
            r_state <= S_WR_RSP;
          end
        end
        S_WR_RSP: begin
          if (w_rsp_ok) begin
            if (r_idx == LAST_IDX) begin
              r_state <= S_TRIG_REQ;
            end else begin
              r_idx   <= r_idx + 6'd1;
              r_state <= S_WR_REQ;
            end
          end
        end
        S_TRIG_REQ: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_add  <= BASE_ADDR + REG_TRIGGER;
            r_wen  <= 1'b0;
            r_data <= 32'd0;
          end else if (gnt_i) begin
            r_req   <= 1'b0;
            // the job may finish before TRIGGER is acknowledged
            r_evt   <= evt_i;
            r_state <= S_TRIG_RSP;
          end
        end
        S_TRIG_RSP: begin
          r_evt <= r_evt | evt_i;
          if (w_rsp_ok) begin
            r_state <= S_WAIT_EVT;
          end
        end
        S_WAIT_EVT: begin
          if (evt_i || r_evt) begin
            r_abort <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_error <= r_abort;
          r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
